// File: rtl/disp_share_ctrl.sv
// Round-robin time-sharing of the two-digit display among NUM_REQ requesters: dwell, blank gap, next owner.
// All outputs registered, one cycle behind req/req_num; no backpressure, requests are level-held.
module disp_share_ctrl #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 12000000,
    parameter int GAP_CYCLES  = 1200000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_num,
    output logic [NUM_REQ-1:0]     grant,
    output logic [3:0]             num1,
    output logic [3:0]             num2,
    output logic                   disp_on,
    output logic                   bcd_err
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   last_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [3:0]         num1_q;
    logic [3:0]         num2_q;
    logic               disp_on_q;
    logic               bcd_err_q;

    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   ld_idx;
    logic [7:0]         ld_raw;
    logic [3:0]         num1_d;
    logic [3:0]         num2_d;
    logic               ld_bad;
    logic               owner_req;
    logic               rival_req;
    logic               hold_done;
    logic               gap_done;
    logic               enter_show;

    // Search starts one past the last owner and wraps; first requester found wins.
    always_comb begin : arb
        int cand;
        cand    = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_vld && req[IDX_W'(cand)]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    // While showing, digits track the current owner; otherwise they come from the new winner.
    always_comb begin
        ld_idx = (state_q == SHOW) ? last_q : win_idx;
        ld_raw = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ld_idx == IDX_W'(i)) begin
                ld_raw = req_num[8*i +: 8];
            end
        end
        num1_d = (ld_raw[7:4] > 4'd9) ? 4'd0 : ld_raw[7:4];
        num2_d = (ld_raw[3:0] > 4'd9) ? 4'd0 : ld_raw[3:0];
        ld_bad = (ld_raw[7:4] > 4'd9) || (ld_raw[3:0] > 4'd9);
    end

    assign owner_req  = |(req & grant_q);
    assign rival_req  = |(req & ~grant_q);
    assign hold_done  = (cnt_q == HOLD_LAST);
    assign gap_done   = (cnt_q == GAP_LAST);
    assign enter_show = win_vld && ((state_q == IDLE) || ((state_q == GAP) && gap_done));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= LAST_RST;
            grant_q   <= '0;
            num1_q    <= '0;
            num2_q    <= '0;
            disp_on_q <= 1'b0;
            bcd_err_q <= 1'b0;
        end else if (enter_show) begin
            state_q   <= SHOW;
            cnt_q     <= '0;
            last_q    <= win_idx;
            grant_q   <= win_oh;
            disp_on_q <= 1'b1;
            num1_q    <= num1_d;
            num2_q    <= num2_d;
            if (ld_bad) begin
                bcd_err_q <= 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                end
                SHOW: begin
                    if (!owner_req || (hold_done && rival_req)) begin
                        state_q   <= GAP;
                        cnt_q     <= '0;
                        grant_q   <= '0;
                        disp_on_q <= 1'b0;
                        num1_q    <= '0;
                        num2_q    <= '0;
                    end else begin
                        cnt_q  <= hold_done ? '0 : cnt_q + CNT_W'(1);
                        num1_q <= num1_d;
                        num2_q <= num2_d;
                        if (ld_bad) begin
                            bcd_err_q <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    grant_q   <= '0;
                    disp_on_q <= 1'b0;
                    num1_q    <= '0;
                    num2_q    <= '0;
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign num1    = num1_q;
    assign num2    = num2_q;
    assign disp_on = disp_on_q;
    assign bcd_err = bcd_err_q;

endmodule

// File: tb/tb_disp_share_ctrl.sv
// Bench for disp_share_ctrl: directed scenarios plus randomized traffic against a countdown-based reference model.
module tb_disp_share_ctrl;

    localparam int N    = 4;
    localparam int HOLD = 8;
    localparam int GAP  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_num;
    logic [N-1:0]   grant;
    logic [3:0]     num1;
    logic [3:0]     num2;
    logic           disp_on;
    logic           bcd_err;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 none), dwell cycles left, blank cycles left.
    int           m_owner;
    int           m_last;
    int           m_left;
    int           m_gap;
    logic [N-1:0] m_grant;
    logic [3:0]   m_n1;
    logic [3:0]   m_n2;
    logic         m_on;
    logic         m_err;

    always #5 clk = ~clk;

    disp_share_ctrl #(.NUM_REQ(N), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .req(req), .req_num(req_num),
        .grant(grant), .num1(num1), .num2(num2), .disp_on(disp_on), .bcd_err(bcd_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic model_outs();
        m_grant = '0;
        if (m_owner >= 0) m_grant[m_owner] = 1'b1;
        m_on = (m_owner >= 0);
    endtask

    task automatic model_reset();
        m_owner = -1; m_last = N - 1; m_left = 0; m_gap = 0;
        m_n1 = 0; m_n2 = 0; m_err = 1'b0;
        model_outs();
    endtask

    task automatic model_load(input int who);
        logic [7:0] v;
        v = 8'(req_num >> (8 * who));
        m_n1 = v[7:4];
        m_n2 = v[3:0];
        if (v[7:4] > 9) begin m_n1 = 0; m_err = 1'b1; end
        if (v[3:0] > 9) begin m_n2 = 0; m_err = 1'b1; end
    endtask

    task automatic model_pick();
        m_owner = -1; m_n1 = 0; m_n2 = 0;
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (m_last + i) % N;
            if (m_owner < 0 && req[c]) begin
                m_owner = c; m_last = c; m_left = HOLD;
                model_load(c);
            end
        end
    endtask

    task automatic model_step();
        if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) model_pick();
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1; m_gap = GAP; m_n1 = 0; m_n2 = 0;
            end else begin
                logic [N-1:0] others;
                others = req;
                others[m_owner] = 1'b0;
                m_left--;
                if (m_left == 0 && others != 0) begin
                    m_owner = -1; m_gap = GAP; m_n1 = 0; m_n2 = 0;
                end else begin
                    if (m_left == 0) m_left = HOLD;
                    model_load(m_owner);
                end
            end
        end else begin
            model_pick();
        end
        model_outs();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_num = '0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (num1 !== 4'd0) begin errors++; $display("FAIL reset_num1: got %0d want 0", num1); end
        checks++; if (num2 !== 4'd0) begin errors++; $display("FAIL reset_num2: got %0d want 0", num2); end
        checks++; if (disp_on !== 1'b0) begin errors++; $display("FAIL reset_disp_on: got %b want 0", disp_on); end
        checks++; if (bcd_err !== 1'b0) begin errors++; $display("FAIL reset_bcd_err: got %b want 0", bcd_err); end
        rst = 1'b0;
    endtask

    task automatic test_single_hold();
        int breaks;
        do_reset();
        req = 4'b0001; req_num = 32'h0000_0042;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", grant); end
        checks++; if (num1 !== 4'd4) begin errors++; $display("FAIL single_num1: got %0d want 4", num1); end
        checks++; if (num2 !== 4'd2) begin errors++; $display("FAIL single_num2: got %0d want 2", num2); end
        checks++; if (disp_on !== 1'b1) begin errors++; $display("FAIL single_disp_on: got %b want 1", disp_on); end
        breaks = 0;
        repeat (20) begin
            tick();
            if (grant !== 4'b0001 || disp_on !== 1'b1) breaks++;
        end
        checks++; if (breaks != 0) begin errors++; $display("FAIL single_no_gap: %0d cycles lost grant, want 0", breaks); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g[$];
        logic [N-1:0] sv[$];
        int           sl[$];
        logic [N-1:0] ev[9];
        int           el[8];
        ev = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        el = '{HOLD, GAP, HOLD, GAP, HOLD, GAP, HOLD, GAP};
        do_reset();
        req = 4'b1111; req_num = 32'h8967_4523;
        repeat (50) begin
            tick();
            g.push_back(grant);
        end
        for (int i = 0; i < g.size(); i++) begin
            if (i == 0 || g[i] !== g[i-1]) begin
                sv.push_back(g[i]); sl.push_back(1);
            end else begin
                sl[sl.size()-1]++;
            end
        end
        checks++;
        if (sv.size() < 9) begin
            errors++; $display("FAIL rr_segments: got %0d segments want at least 9", sv.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (sv[i] !== ev[i]) begin errors++; $display("FAIL rr_owner[%0d]: got %b want %b", i, sv[i], ev[i]); end
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (sl[i] != el[i]) begin errors++; $display("FAIL rr_length[%0d]: got %0d want %0d", i, sl[i], el[i]); end
            end
        end
    endtask

    task automatic test_release();
        int stray;
        do_reset();
        req = 4'b0001; req_num = 32'h0000_0042;
        tick();
        repeat (3) tick();
        req = 4'b0000;
        tick();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL release_grant: got %b want 0000", grant); end
        checks++; if (disp_on !== 1'b0) begin errors++; $display("FAIL release_disp_on: got %b want 0", disp_on); end
        stray = 0;
        repeat (6) begin
            tick();
            if (grant !== 4'b0000 || disp_on !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL release_idle: %0d cycles active, want 0", stray); end
        req = 4'b0001;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL idle_regrant: got %b want 0001", grant); end
        req = 4'b0000;
        tick();
        req = 4'b0001;
        tick();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL gap_ignores_req: got %b want 0000", grant); end
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL gap_end_grant: got %b want 0001", grant); end
    endtask

    task automatic test_live_update();
        do_reset();
        req = 4'b0010; req_num = 32'h0000_1200;
        tick();
        checks++; if (grant !== 4'b0010 || num1 !== 4'd1 || num2 !== 4'd2) begin
            errors++; $display("FAIL live_initial: got %b %0d%0d want 0010 12", grant, num1, num2);
        end
        tick(); tick();
        req_num[15:8] = 8'h57;
        tick();
        checks++; if (num1 !== 4'd5) begin errors++; $display("FAIL live_num1: got %0d want 5", num1); end
        checks++; if (num2 !== 4'd7) begin errors++; $display("FAIL live_num2: got %0d want 7", num2); end
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL live_grant: got %b want 0010", grant); end
    endtask

    task automatic test_bcd_err();
        do_reset();
        req = 4'b0001; req_num = 32'hFF00_0042;
        repeat (3) tick();
        checks++; if (bcd_err !== 1'b0) begin errors++; $display("FAIL bcd_non_owner: got %b want 0", bcd_err); end
        do_reset();
        req = 4'b0100; req_num = 32'h00A3_0000;
        tick();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL bcd_grant: got %b want 0100", grant); end
        checks++; if (num1 !== 4'd0) begin errors++; $display("FAIL bcd_num1: got %0d want 0", num1); end
        checks++; if (num2 !== 4'd3) begin errors++; $display("FAIL bcd_num2: got %0d want 3", num2); end
        checks++; if (bcd_err !== 1'b1) begin errors++; $display("FAIL bcd_set: got %b want 1", bcd_err); end
        req = 4'b0000;
        repeat (6) tick();
        checks++; if (bcd_err !== 1'b1) begin errors++; $display("FAIL bcd_sticky: got %b want 1", bcd_err); end
        do_reset();
        checks++; if (bcd_err !== 1'b0) begin errors++; $display("FAIL bcd_cleared: got %b want 0", bcd_err); end
    endtask

    task automatic test_reset_mid_show();
        do_reset();
        req = 4'b0100; req_num = 32'h0019_0000;
        tick(); tick();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL midrst_pre: got %b want 0100", grant); end
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++; if (grant !== 4'b0000 || disp_on !== 1'b0) begin
            errors++; $display("FAIL midrst_async: grant %b disp_on %b want 0000 0", grant, disp_on);
        end
        checks++; if (num1 !== 4'd0 || num2 !== 4'd0) begin
            errors++; $display("FAIL midrst_nums: got %0d%0d want 00", num1, num2);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL midrst_regrant: got %b want 0100", grant); end
        do_reset();
        req = 4'b0101; req_num = 32'h0033_0011;
        repeat (HOLD + GAP + 1) tick();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL midrst_second_owner: got %b want 0100", grant); end
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL midrst_last_owner: got %b want 0001", grant); end
    endtask

    task automatic test_expiry_edges();
        do_reset();
        req = 4'b0001; req_num = 32'h0000_5511;
        tick();
        repeat (HOLD - 1) tick();
        req = 4'b0011;
        tick();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL expiry_rival: got %b want 0000", grant); end
        repeat (GAP) tick();
        checks++; if (grant !== 4'b0010 || num1 !== 4'd5 || num2 !== 4'd5) begin
            errors++; $display("FAIL expiry_next: got %b %0d%0d want 0010 55", grant, num1, num2);
        end
        do_reset();
        req = 4'b0001;
        tick();
        repeat (HOLD - 1) tick();
        req = 4'b0000;
        tick();
        checks++; if (grant !== 4'b0000 || disp_on !== 1'b0) begin
            errors++; $display("FAIL expiry_release: grant %b disp_on %b want 0000 0", grant, disp_on);
        end
    endtask

    task automatic test_random();
        do_reset();
        req = '0; req_num = 32'h1234_5678;
        for (int c = 0; c < 600 && errors < 20; c++) begin
            int         k;
            logic [3:0] t;
            logic [3:0] u;
            if (c % 200 == 199) do_reset();
            if ($urandom_range(0, 9) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, N - 1);
                t = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                u = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                req_num[8*k +: 8] = {t, u};
            end
            tick();
            checks++; if (grant !== m_grant) begin errors++; $display("FAIL rand_grant c=%0d: got %b want %b", c, grant, m_grant); end
            checks++; if (num1 !== m_n1) begin errors++; $display("FAIL rand_num1 c=%0d: got %0d want %0d", c, num1, m_n1); end
            checks++; if (num2 !== m_n2) begin errors++; $display("FAIL rand_num2 c=%0d: got %0d want %0d", c, num2, m_n2); end
            checks++; if (disp_on !== m_on) begin errors++; $display("FAIL rand_disp_on c=%0d: got %b want %b", c, disp_on, m_on); end
            checks++; if (bcd_err !== m_err) begin errors++; $display("FAIL rand_bcd_err c=%0d: got %b want %b", c, bcd_err, m_err); end
            checks++; if (!$onehot0(grant) || disp_on !== (|grant)) begin
                errors++; $display("FAIL rand_onehot c=%0d: grant %b disp_on %b", c, grant, disp_on);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_hold();
        test_round_robin();
        test_release();
        test_live_update();
        test_bcd_err();
        test_reset_mid_show();
        test_expiry_edges();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_share_ctrl.md
# disp_share_ctrl

Time-sharing scheduler for the two-digit seven-segment display decoder. Up to NUM_REQ requesters each want to show a two-digit BCD value. The block picks one at a time in round-robin order and holds it on the display for a fixed dwell. Between owners it blanks the display for a short gap. Its num1/num2/disp_on outputs drive the decoder's digit inputs and the LED enable.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- HOLD_CYCLES, 12000000, dwell per grant in clk cycles (1 s at 12 MHz); minimum 2
- GAP_CYCLES, 1200000, blank interval between different owners; minimum 1
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous assert, active-high
- req  in  NUM_REQ  per-requester display request, level-sensitive
- req_num  in  8*NUM_REQ  requester i value at bits [8i+7:8i]; [7:4] = tens digit, [3:0] = units digit
- grant  out  NUM_REQ  one-hot current owner; all-zero when no owner
- num1  out  4  tens digit to decoder
- num2  out  4  units digit to decoder
- disp_on  out  1  display enable; 0 = blank
- bcd_err  out  1  sticky flag: an owner presented a digit > 9

## Operation
- States: IDLE, SHOW, GAP. All outputs registered.
- IDLE:
  - grant = 0, disp_on = 0, num1 = num2 = 0.
  - If any req is high, arbitrate and enter SHOW.
- Arbitration is round-robin:
  - Search starts at index (last_owner+1) mod NUM_REQ and wraps.
  - The first requester with req high wins.
  - last_owner resets to NUM_REQ-1, so requester 0 wins first after reset.
- SHOW:
  - grant holds the winner's one-hot bit and disp_on = 1.
  - Every cycle, num1/num2 register the owner's current req_num digits, so live updates reach the display with 1-cycle latency.
  - A digit > 9 is output as 0 for that digit and sets bcd_err.
  - The dwell counter runs 0..HOLD_CYCLES-1.
- Leaving SHOW, first match wins:
  - Owner's req low → GAP immediately, even mid-dwell. This is a release.
  - Dwell expired and another requester has req high → GAP.
  - Dwell expired and only the owner has req high → stay in SHOW, restart the counter, no gap, grant unchanged.
- GAP:
  - grant = 0, disp_on = 0, num1 = num2 = 0.
  - Gap counter runs 0..GAP_CYCLES-1.
  - At expiry, arbitrate: a winner → SHOW; no requester → IDLE.
  - Requests changing during GAP are ignored until expiry.
- last_owner updates only on entry to SHOW.
- bcd_err:
  - Clears only on rst.
  - Only the owner's digits are checked, and only in SHOW.
- Reset mid-operation:
  - State, counters, grant, num1, num2, disp_on and bcd_err go to reset values immediately.
  - last_owner returns to NUM_REQ-1.

## Timing
- Reset values: state IDLE, grant 0, num1 0, num2 0, disp_on 0, bcd_err 0.
- Grant from IDLE:
  - req sampled high at edge k → at edge k+1, grant, disp_on and num1/num2 reflect the winner.
  - num1/num2 carry the winner's req_num sampled at edge k.
- Dwell and gap lengths:
  - Full dwell: grant high for exactly HOLD_CYCLES cycles.
  - Gap: disp_on low for exactly GAP_CYCLES cycles between owners.
  - Next owner's grant rises the cycle after the gap ends.
- Release:
  - Owner's req sampled low at edge k → grant and disp_on low at edge k+1.
  - GAP then runs its full length.
- Simultaneous events:
  - Release on the last dwell cycle is treated as a release (GAP).
  - A new request arriving on the dwell-expiry edge counts as competing.
- grant is never multi-hot. disp_on = 1 if and only if grant ≠ 0.

## Test plan
All scenarios use NUM_REQ=4, HOLD_CYCLES=8, GAP_CYCLES=2.
- Reset, then req=0001 with req_num[7:0]=8'h42:
  - Grant 0001 one cycle later; num1=4, num2=2, disp_on=1.
  - Grant held continuously past 16 cycles with no gap.
- req=1111 held, each req_num distinct:
  - Owners in order 0,1,2,3,0.
  - Each owns exactly 8 cycles, separated by exactly 2 blank cycles.
- Owner 0 active, req0 dropped at dwell cycle 3:
  - grant=0 and disp_on=0 next cycle.
  - 2-cycle gap, then IDLE if no requests remain.
- Owner 1 active with req_num[15:8] changed 8'h12 → 8'h57 mid-dwell:
  - Display reads 5,7 one cycle later; grant unchanged.
- Owner 2 presents 8'hA3:
  - num1=0, num2=3, bcd_err=1.
  - bcd_err stays 1 after owner 2 releases, until rst.
- rst pulsed mid-SHOW with req=0100 held:
  - Outputs reset immediately.
  - After release of rst, requester 2 is granted, since the search starts from 0.
